// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider for the EX stage (DIV/DIVU).
// Produces {remainder, quotient}; the remainder takes the dividend's sign.
module div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_BYZERO = 2'b01;
    localparam logic [1:0] S_ON     = 2'b10;
    localparam logic [1:0] S_DONE   = 2'b11;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_dividend;   // shifts out dividend bits, shifts in quotient bits
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_rem;
    logic               r_sign1;
    logic               r_sign2;
    logic [2*WIDTH-1:0] r_result;
    logic [2*WIDTH-1:0] r_result_o;
    logic               r_ready;

    logic               w_go;
    logic               w_last;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH:0]     w_hi;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_go   = start_i && !annul_i;
    assign w_last = (r_cnt == CW'(WIDTH));

    // Operand magnitudes; the most negative value maps to itself as an unsigned magnitude
    assign w_abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign w_abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // One restoring step: shift next dividend bit into the partial remainder, trial-subtract
    assign w_hi       = {r_rem, r_dividend[WIDTH-1]};
    assign w_ge       = (w_hi >= {1'b0, r_divisor});
    assign w_rem_next = w_ge ? WIDTH'(w_hi - {1'b0, r_divisor}) : w_hi[WIDTH-1:0];

    // Sign correction; sign flags are only ever set for signed operations
    assign w_quot_fix = (r_sign1 ^ r_sign2) ? -r_dividend : r_dividend;
    assign w_rem_fix  = r_sign1 ? -r_rem : r_rem;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; annul_i wins over everything
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_state_next = (opdata2_i == '0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: w_state_next = annul_i ? S_IDLE : S_DONE;
            S_ON: begin
                if (annul_i) begin
                    w_state_next = S_IDLE;
                end else if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!w_go) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and final result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_sign1    <= 1'b0;
            r_sign2    <= 1'b0;
            r_result   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_sign1    <= signed_div_i && opdata1_i[WIDTH-1];
                        r_sign2    <= signed_div_i && opdata2_i[WIDTH-1];
                        r_dividend <= w_abs1;
                        r_divisor  <= w_abs2;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                    end
                end
                S_BYZERO: begin
                    r_result <= '0;
                end
                S_ON: begin
                    if (!annul_i) begin
                        if (w_last) begin
                            r_result <= {w_rem_fix, w_quot_fix};
                        end else begin
                            r_rem      <= w_rem_next;
                            r_dividend <= {r_dividend[WIDTH-2:0], w_ge};
                            r_cnt      <= r_cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs: presented only while sitting in DONE with the request still held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready    <= 1'b0;
            r_result_o <= '0;
        end else if (r_state == S_DONE && w_go) begin
            r_ready    <= 1'b1;
            r_result_o <= r_result;
        end else begin
            r_ready    <= 1'b0;
            r_result_o <= '0;
        end
    end

    assign ready_o  = r_ready;
    assign result_o = r_result_o;

endmodule
